// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 adder/subtractor with parametrised exponent/fraction widths,
// round-to-nearest-even, flush-to-zero denormals and a single stall signal for the whole pipe.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_op,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_s,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             out_flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;   // {hidden, frac, G, R, S}
    localparam int NW = MAN_W + 5;   // carry + SW
    localparam int EW = EXP_W + 2;   // signed exponent headroom for normalisation
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic              spec;
        logic [W-1:0]      spec_val;
        logic [3:0]        spec_flags;
        logic              sign;
        logic              sub;
        logic [EXP_W-1:0]  exp;
        logic [SW-1:0]     sig_l;
        logic [SW-1:0]     sig_r;
        logic [TAG_W-1:0]  tag;
    } s1_t;

    typedef struct packed {
        logic              spec;
        logic [W-1:0]      spec_val;
        logic [3:0]        spec_flags;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [NW-1:0]     sum;
        logic [TAG_W-1:0]  tag;
    } s2_t;

    logic advance;
    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, out_valid_q, out_valid_d;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    logic [W-1:0]     out_s_q, out_s_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [3:0]       out_flags_q, out_flags_d;

    logic                   a_s, b_s, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
    logic [EXP_W-1:0]       a_e, b_e, l_e, r_e, shamt;
    logic [MAN_W-1:0]       a_f, b_f, l_f, r_f;
    logic [EXP_W+MAN_W-1:0] a_mag, b_mag;
    logic                   swap, l_s, r_zero, al_sticky, inf_sub;
    logic [MAN_W:0]         sig_r;
    logic [MAN_W+2:0]       ext, al_main;

    logic [EW-1:0]    lz, e_n, e_r;
    logic [SW-1:0]    norm;
    logic [MAN_W:0]   mant;
    logic [MAN_W+1:0] mant_r;
    logic             g_b, r_b, s_b, rnd;
    logic [MAN_W-1:0] frac;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_s     = out_s_q;
    assign out_tag   = out_tag_q;
    assign out_flags = out_flags_q;

    // S1: unpack, classify, order by magnitude, align the smaller operand
    always_comb begin
        a_s    = in_a[W-1];
        a_e    = in_a[W-2 -: EXP_W];
        a_f    = in_a[MAN_W-1:0];
        b_s    = in_b[W-1] ^ in_op;
        b_e    = in_b[W-2 -: EXP_W];
        b_f    = in_b[MAN_W-1:0];
        a_zero = (a_e == '0);
        b_zero = (b_e == '0);
        a_nan  = (&a_e) && (|a_f);
        b_nan  = (&b_e) && (|b_f);
        a_inf  = (&a_e) && !(|a_f);
        b_inf  = (&b_e) && !(|b_f);
        a_snan = a_nan && !a_f[MAN_W-1];
        b_snan = b_nan && !b_f[MAN_W-1];
        a_mag  = a_zero ? '0 : {a_e, a_f};
        b_mag  = b_zero ? '0 : {b_e, b_f};
        swap   = b_mag > a_mag;
        l_s    = swap ? b_s : a_s;
        l_e    = swap ? b_e : a_e;
        l_f    = swap ? b_f : a_f;
        r_e    = swap ? a_e : b_e;
        r_f    = swap ? a_f : b_f;
        r_zero = swap ? a_zero : b_zero;
        sig_r  = r_zero ? '0 : {1'b1, r_f};
        shamt  = l_e - r_e;
        ext    = {sig_r, 2'b00};
        if (int'(shamt) >= MAN_W + 3) begin
            al_main   = '0;
            al_sticky = |sig_r;
        end else begin
            al_main   = ext >> shamt;
            al_sticky = |(ext & ~({(MAN_W+3){1'b1}} << shamt));
        end
        inf_sub = a_inf && b_inf && (a_s != b_s);

        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (advance) begin
            s1_valid_d      = in_valid;
            s1_d.spec       = 1'b1;
            s1_d.spec_val   = '0;
            s1_d.spec_flags = '0;
            if (a_nan || b_nan || inf_sub) begin
                s1_d.spec_val   = QNAN;
                s1_d.spec_flags = {a_snan || b_snan || inf_sub, 3'b000};
            end else if (a_inf) begin
                s1_d.spec_val = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (b_inf) begin
                s1_d.spec_val = {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (a_zero && b_zero) begin
                s1_d.spec_val = {a_s && b_s, {(W-1){1'b0}}};
            end else begin
                s1_d.spec = 1'b0;
            end
            s1_d.sign  = l_s;
            s1_d.sub   = a_s != b_s;
            s1_d.exp   = l_e;
            s1_d.sig_l = {1'b1, l_f, 3'b000};
            s1_d.sig_r = {al_main, al_sticky};
            s1_d.tag   = in_tag;
        end
    end

    // S2: L >= R in magnitude, so the effective subtraction never goes negative
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (advance) begin
            s2_valid_d      = s1_valid_q;
            s2_d.spec       = s1_q.spec;
            s2_d.spec_val   = s1_q.spec_val;
            s2_d.spec_flags = s1_q.spec_flags;
            s2_d.sign       = s1_q.sign;
            s2_d.exp        = s1_q.exp;
            s2_d.tag        = s1_q.tag;
            s2_d.sum        = s1_q.sub ? ({1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_r})
                                       : ({1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_r});
        end
    end

    // S3: normalise, round to nearest even, detect range exceptions, pack
    always_comb begin
        lz = '0;
        for (int unsigned i = 0; i < NW - 1; i++) begin
            if (s2_q.sum[i]) lz = EW'(NW - 2 - i);
        end
        if (s2_q.sum[NW-1]) begin
            norm = {s2_q.sum[NW-1:2], s2_q.sum[1] | s2_q.sum[0]};
            e_n  = {2'b00, s2_q.exp} + EW'(1);
        end else begin
            norm = s2_q.sum[SW-1:0] << lz;
            e_n  = {2'b00, s2_q.exp} - lz;
        end
        mant   = norm[SW-1:3];
        g_b    = norm[2];
        r_b    = norm[1];
        s_b    = norm[0];
        rnd    = g_b && (r_b || s_b || mant[0]);
        mant_r = {1'b0, mant} + (MAN_W+2)'(rnd);
        e_r    = e_n + EW'(mant_r[MAN_W+1]);
        frac   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

        out_valid_d = out_valid_q;
        out_s_d     = out_s_q;
        out_tag_d   = out_tag_q;
        out_flags_d = out_flags_q;
        if (advance) begin
            out_valid_d = s2_valid_q;
            out_tag_d   = s2_q.tag;
            if (s2_q.spec) begin
                out_s_d     = s2_q.spec_val;
                out_flags_d = s2_q.spec_flags;
            end else if (s2_q.sum == '0) begin
                out_s_d     = '0;
                out_flags_d = '0;
            end else if (e_n[EW-1] || (e_n == '0)) begin
                out_s_d     = {s2_q.sign, {(W-1){1'b0}}};
                out_flags_d = 4'b0011;
            end else if (e_r >= EW'((1 << EXP_W) - 1)) begin
                out_s_d     = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                out_flags_d = 4'b0101;
            end else begin
                out_s_d     = {s2_q.sign, e_r[EXP_W-1:0], frac};
                out_flags_d = {3'b000, g_b || r_b || s_b};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            out_s_q     <= '0;
            out_tag_q   <= '0;
            out_flags_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_s_q     <= out_s_d;
            out_tag_q   <= out_tag_d;
            out_flags_q <= out_flags_d;
        end
    end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754 floating-point adder/subtractor. It is the successor to the team's combinational single-precision adder.
- New capabilities:
  - configurable exponent and mantissa widths
  - runtime add/sub select
  - round-to-nearest-even
  - special-value handling
  - exception flags
  - 3-stage valid/ready pipeline
- Sits between operand issue logic and the result writeback in the multi-precision FP datapath.

Parameters:
- EXP_W, 8, exponent field width (8 gives binary32; 5 gives binary16; 11 gives binary64).
- MAN_W, 23, stored fraction width (hidden bit is not stored).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- in_op  in  1  0 = A+B, 1 = A−B (implemented as an inversion of B's sign).
- in_a  in  1+EXP_W+MAN_W  operand A, packed {sign, exp, frac}.
- in_b  in  1+EXP_W+MAN_W  operand B.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_s  out  1+EXP_W+MAN_W  rounded result.
- out_tag  out  TAG_W  tag of the operation in out_s.
- out_flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits clear
  - out_valid = 0, out_s = 0, out_tag = 0, out_flags = 0
  - in_ready = 1 after reset
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - A transfer occurs when in_valid && in_ready.
  - The whole pipe stalls when advance = 0. Stage registers hold, and out_s, out_tag and out_flags stay stable while out_valid && !out_ready.
  - Bubbles propagate as invalid stages; there is no bubble collapsing.
- Latency: exactly 3 cycles from accept to out_valid when out_ready stays high. Throughput is 1 op per clock.
- S1, unpack/compare/align:
  - Apply in_op to B's sign.
  - Swap so that operand L has magnitude ≥ operand R (compare {exp, frac}); on a tie A is L.
  - Shift R's significand (hidden bit = 1 if exp ≠ 0) right by expL − expR, keeping guard, round and a sticky OR of all shifted-out bits.
  - A shift ≥ MAN_W+3 leaves only sticky.
  - Classify zero/inf/NaN.
- S2, add/subtract: effective subtraction when the signs differ; the result sign is L's sign. The sum uses a MAN_W+5-bit datapath (carry, hidden, frac, G, R, S).
- S3, normalise/round/pack:
  - Normalisation:
    - On carry out: shift right 1 and increment the exponent, folding the lost bit into sticky.
    - Otherwise: leading-zero count, shift left, and decrement the exponent.
  - Round to nearest, ties to even. A mantissa overflow from rounding re-increments the exponent.
- Denormals: flush-to-zero. Inputs with exp = 0 are treated as signed zero. Results with exponent ≤ 0 after normalisation become signed zero with underflow = 1 and inexact = 1.
- Overflow: exponent ≥ 2^EXP_W − 1 after rounding gives ±inf, with overflow = 1 and inexact = 1.
- Exact cancellation (magnitude 0) gives +0. (−0) + (−0) gives −0.
- Special values:
  - Any NaN input, or inf − inf under the effective operation, gives the canonical quiet NaN {0, all-ones, 1 followed by zeros}.
  - invalid = 1 only for signalling-NaN inputs or inf − inf.
  - inf ± finite gives that inf with no flags.
- inexact = 1 whenever G|R|S ≠ 0 before rounding.
- Reset asserted mid-operation discards all in-flight ops; no partial result ever appears.

Test Plan (defaults, binary32):
- 1: in_a = 3F800000, in_b = 3F800000, op = 0 → 3 cycles later out_s = 40000000, flags = 0000, tag echoed.
- 2: in_a = 40400000, in_b = 3F800000, op = 1 → out_s = 40000000. Then in_a = 3FC00000, in_b = 3FC00000, op = 1 → out_s = 00000000.
- 3: in_a = 3F800000, in_b = 33800000 (2^-24, exact tie) → out_s = 3F800000, inexact = 1. Then in_b = 33800001 → out_s = 3F800001, inexact = 1.
- 4: in_a = in_b = 7F7FFFFF, op = 0 → out_s = 7F800000, overflow = 1, inexact = 1. Then in_a = 7F800000, in_b = FF800000 → out_s = 7FC00000, invalid = 1.
- 5: Back-to-back stream of 8 ops with out_ready toggling 1,0,0,1: no op lost or duplicated, outputs stable while stalled, in_ready low exactly when out_valid && !out_ready, tags in order.
- 6: Assert rst_n = 0 with 3 ops in flight → out_valid falls immediately (async). After release no stale result appears and in_ready = 1.
